alu_seq: RTL and testbench

//  Parametrised, handshaked ALU for the MINI_CPU datapath.
//  - Generalises the 8-bit, 4-op combinational ALU to WIDTH bits and 8 ops.
//  - Adds a full NZCV flag set, registered outputs and an iterative multi-cycle multiply.
//  - Sits between operand fetch (valid/ready source) and writeback (valid/ready sink).

---
 rtl/alu_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with NZCV flags, registered outputs and
// an iterative shift-add multiplier.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (op_a, op_b, alu_op)
//   op_a, op_b           operands (op_b low bits are the shift amount)
//   alu_op               000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                        101 SHL, 110 SHR, 111 MUL
//   out_valid / out_ready result handshake (result + flags)
//   result               operation result
//   zero, negative       result == 0, result MSB
//   carry                carry / borrow / last bit shifted out / MUL high half nonzero
//   overflow             signed overflow, ADD/SUB only
//   busy                 multiply in progress
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             n;
      logic             c;
      logic             v;
   } alu_out_t;

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
   endfunction

   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
   endfunction

   // Single-cycle ops. MUL (and the unsupported op when MUL_EN=0) falls to
   // the default: result 0, zero set, other flags clear.
   function automatic alu_out_t alu_eval(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [2:0]       op);
      alu_out_t       o;
      logic [WIDTH:0] ext;
      logic [SHW-1:0] amt;
      o   = '0;
      ext = '0;
      amt = b[SHW-1:0];
      case (op)
         OP_ADD: begin
            ext   = {1'b0, a} + {1'b0, b};
            o.res = ext[WIDTH-1:0];
            o.c   = ext[WIDTH];
            o.v   = add_ovf(a, b, ext[WIDTH-1:0]);
         end
         OP_SUB: begin
            // bit WIDTH of the extended difference is the borrow
            ext   = {1'b0, a} - {1'b0, b};
            o.res = ext[WIDTH-1:0];
            o.c   = ext[WIDTH];
            o.v   = sub_ovf(a, b, ext[WIDTH-1:0]);
         end
         OP_AND: o.res = a & b;
         OP_OR:  o.res = a | b;
         OP_XOR: o.res = a ^ b;
         OP_SHL: begin
            // one guard bit above the MSB catches the last bit shifted out
            ext   = {1'b0, a} << amt;
            o.res = ext[WIDTH-1:0];
            o.c   = ext[WIDTH];
         end
         OP_SHR: begin
            // one guard bit below the LSB catches the last bit shifted out
            ext   = {a, 1'b0} >> amt;
            o.res = ext[WIDTH:1];
            o.c   = ext[0];
         end
         default: o.res = '0;
      endcase
      o.z = ~|o.res;
      o.n = o.res[WIDTH-1];
      return o;
   endfunction

   state_t             state;
   logic               accept;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH-1:0]   mplier;
   alu_out_t           ev;

   assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign ev        = alu_eval(op_a, op_b, alu_op);
   assign prod_next = prod + (mplier[0] ? mcand : '0);

   // ---- multiplier datapath: load on accept, one multiplier bit per MUL cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand  <= {{WIDTH{1'b0}}, op_a};
         mplier <= op_b;
         prod   <= '0;
      end else if (state == S_MUL) begin
         prod   <= prod_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   // ---- control and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (MUL_EN && (alu_op == OP_MUL)) begin
                     state     <= S_MUL;
                     cnt       <= '0;
                     busy      <= 1'b1;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     result    <= ev.res;
                     zero      <= ev.z;
                     negative  <= ev.n;
                     carry     <= ev.c;
                     overflow  <= ev.v;
                  end
               end else if ((state == S_DONE) && out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            S_MUL: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= prod_next[WIDTH-1:0];
                  zero      <= ~|prod_next[WIDTH-1:0];
                  negative  <= prod_next[WIDTH-1];
                  carry     <= |prod_next[2*WIDTH-1:WIDTH];
                  overflow  <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8, MUL_EN=1).
// Table vectors with hand-computed results, stall/back-to-back and
// mid-multiply reset sequences, then random operations against an
// integer-arithmetic reference model.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [2:0] alu_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero, negative, carry, overflow, busy;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] res;
      logic       z, n, c, v;
      int         lat;
      int         bsy;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic, returns {res, z, n, c, v}.
   function automatic logic [11:0] model(input int a, input int b, input int op);
      int r, c, v, t, amt, sa, sb;
      logic [7:0] rb;
      r = 0; c = 0; v = 0;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      amt = b % 8;
      case (op)
         0: begin t = a + b; r = t % 256; c = (t > 255) ? 1 : 0;
                  t = sa + sb; v = (t > 127 || t < -128) ? 1 : 0; end
         1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
                  t = sa - sb; v = (t > 127 || t < -128) ? 1 : 0; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = (a << amt) % 256; c = (amt == 0) ? 0 : ((a >> (8 - amt)) & 1); end
         6: begin r = a >> amt; c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1); end
         default: begin t = a * b; r = t % 256; c = (t > 255) ? 1 : 0; end
      endcase
      rb = r[7:0];
      return {rb, (r == 0), (r >= 128), (c != 0), (v != 0)};
   endfunction

   // Called just after a negedge; returns at the negedge where out_valid is seen.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         output logic [11:0] got, output int lat, output int bsy);
      logic done;
      op_a = a; op_b = b; alu_op = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0; bsy = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         lat++;
         if (busy) bsy++;
         if (out_valid) done = 1'b1;
      end
      got = {result, zero, negative, carry, overflow};
   endtask

   initial begin
      logic [11:0] got;
      logic [11:0] exp;
      int lat, bsy, seen, ea, eb, eo;

      //              a      b      op    res    z     n     c     v   lat bsy
      tbl[0]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0};
      tbl[1]  = '{8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
      tbl[2]  = '{8'h01, 8'h02, 3'd1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
      tbl[3]  = '{8'h10, 8'h11, 3'd7, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 9, 8};
      tbl[4]  = '{8'h81, 8'h09, 3'd5, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
      tbl[5]  = '{8'h01, 8'h00, 3'd6, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[6]  = '{8'hAA, 8'hAA, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[7]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
      tbl[8]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[9]  = '{8'h0F, 8'hF0, 3'd3, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
      tbl[10] = '{8'hC0, 8'h07, 3'd6, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
      tbl[11] = '{8'hFF, 8'hFF, 3'd7, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 9, 8};
      tbl[12] = '{8'h00, 8'h05, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9, 8};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op_a = '0; op_b = '0; alu_op = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset result_flags", 32'({result, zero, negative, carry, overflow}), 32'd0);

      // table vectors
      foreach (tbl[i]) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].op, got, lat, bsy);
         chk($sformatf("vec%0d result_flags", i), 32'(got),
             32'({tbl[i].res, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v}));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("vec%0d busy_cycles", i), 32'(bsy), 32'(tbl[i].bsy));
      end
      @(negedge clk);
      chk("idle after release", 32'(out_valid), 32'd0);

      // stall with out_ready=0: output held, other requests ignored
      out_ready = 1'b0;
      op_a = 8'h03; op_b = 8'h04; alu_op = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      op_a = 8'h55; op_b = 8'h0F; alu_op = 3'd4;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall out_valid", 32'(out_valid), 32'd1);
         chk("stall result_flags", 32'({result, zero, negative, carry, overflow}), 32'({8'h07, 4'b0000}));
         chk("stall in_ready", 32'(in_ready), 32'd0);
      end
      op_a = 8'h20; op_b = 8'h05; alu_op = 3'd1; out_ready = 1'b1;
      #1;
      chk("release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b out_valid", 32'(out_valid), 32'd1);
      chk("b2b result_flags", 32'({result, zero, negative, carry, overflow}), 32'({8'h1B, 4'b0000}));
      @(negedge clk);
      chk("b2b drained", 32'(out_valid), 32'd0);

      // reset asserted during the 4th multiply cycle
      op_a = 8'h10; op_b = 8'h11; alu_op = 3'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mul busy", 32'(busy), 32'd1);
      chk("mul in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mulrst out_valid", 32'(out_valid), 32'd0);
      chk("mulrst busy", 32'(busy), 32'd0);
      chk("mulrst in_ready", 32'(in_ready), 32'd1);
      chk("mulrst result", 32'(result), 32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      chk("mulrst no stale output", 32'(seen), 32'd0);

      // random operations against the reference model
      for (int i = 0; i < 150; i++) begin
         ea = int'($urandom_range(0, 255));
         eb = int'($urandom_range(0, 255));
         eo = int'($urandom_range(0, 7));
         exp = model(ea, eb, eo);
         run_op(ea[7:0], eb[7:0], eo[2:0], got, lat, bsy);
         chk($sformatf("rand%0d op%0d %0h,%0h", i, eo, ea, eb), 32'(got), 32'(exp));
         chk($sformatf("rand%0d latency", i), 32'(lat), (eo == 7) ? 32'd9 : 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
